// File: rtl/sha256_pkg.sv
// ============================================================================
// Module  : sha256_pkg
// Purpose : Shared widths, FSM state type and block record for the SHA-256
//           front-end issuer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package sha256_pkg;

   localparam int SHA_ID_W    = 6;
   localparam int SHA_BLOCK_W = 512;
   localparam int SHA_CNT_W   = 7;
   localparam int SHA_BATCH_W = 10;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ID_PUSH = 2'd1,
      STREAM  = 2'd2
   } issuer_state_t;

   typedef struct packed {
      logic [SHA_BLOCK_W-1:0] data;
      logic [SHA_ID_W-1:0]    id;
      logic                   last;
   } sha_blk_t;

   // IDs are a plain modulo-64 sequence; live IDs never collide because the
   // credit limit stays below the ID space.
   function automatic logic [SHA_ID_W-1:0] sha_id_inc(input logic [SHA_ID_W-1:0] id);
      return id + SHA_ID_W'(1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/sha256_block_out_reg.sv
// ============================================================================
// Module  : sha256_block_out_reg
// Purpose : Single-entry valid/ready output register holding {data,id,last};
//           sustains one block per cycle when the consumer is always ready.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sha256_block_out_reg
   import sha256_pkg::*;
(
   input  logic     clk,
   input  logic     rst,
   input  logic     sync_rst,
   input  logic     in_valid_i,
   output logic     in_ready_o,
   input  sha_blk_t in_blk_i,
   output logic     out_valid_o,
   input  logic     out_ready_i,
   output sha_blk_t out_blk_o
);

   logic     valid_q;
   sha_blk_t blk_q;

   // A new block may enter when the slot is empty or is being emptied now.
   assign in_ready_o  = !valid_q || out_ready_i;
   assign out_valid_o = valid_q;
   assign out_blk_o   = blk_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         blk_q   <= '0;
      end else if (sync_rst) begin
         valid_q <= 1'b0;
         blk_q   <= '0;
      end else if (in_valid_i && in_ready_o) begin
         valid_q <= 1'b1;
         blk_q   <= in_blk_i;
      end else if (out_ready_i) begin
         valid_q <= 1'b0;
      end
   end

endmodule

`default_nettype wire

// File: rtl/sha256_id_issuer.sv
// ============================================================================
// Module  : sha256_id_issuer
// Purpose : Tags each message packet with a 6-bit ID, pushes the ID to the
//           validator, then streams the packet blocks to the hash engine
//           under a credit limit replenished by hash retirement.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sha256_id_issuer
   import sha256_pkg::*;
#(
   parameter int MAX_OUTSTANDING = 16,
   parameter int BATCH_LEN       = 4
)(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic                   sync_rst,
   input  logic [SHA_BLOCK_W-1:0] data_in,
   input  logic                   data_in_last,
   input  logic                   data_in_valid,
   output logic                   data_in_ready,
   output logic [SHA_BLOCK_W-1:0] data_out,
   output logic [SHA_ID_W-1:0]    data_out_id,
   output logic                   data_out_last,
   output logic                   data_out_valid,
   input  logic                   data_out_ready,
   output logic [SHA_ID_W-1:0]    id_out,
   output logic                   id_out_last,
   output logic                   id_out_valid,
   input  logic                   id_out_ready,
   input  logic                   hash_done,
   output logic [SHA_CNT_W-1:0]   status_outstanding,
   output logic                   status_err
);

   localparam logic [SHA_CNT_W-1:0]   MAX_CNT    = SHA_CNT_W'(MAX_OUTSTANDING);
   localparam logic [SHA_BATCH_W-1:0] BATCH_LAST = SHA_BATCH_W'(BATCH_LEN - 1);

   issuer_state_t         state_q;
   logic [SHA_ID_W-1:0]   id_next_q;
   logic [SHA_ID_W-1:0]   cur_id_q;
   logic [SHA_BATCH_W-1:0] batch_q;
   logic                  id_valid_q;
   logic [SHA_ID_W-1:0]   id_q;
   logic                  id_last_q;
   logic [SHA_CNT_W-1:0]  outstanding_q;
   logic [SHA_CNT_W-1:0]  outstanding_d;
   logic                  err_q;
   logic                  err_d;

   logic     id_hs;
   logic     retire;
   logic     blk_in_valid;
   logic     blk_in_ready;
   logic     blk_load;
   sha_blk_t blk_in;
   sha_blk_t blk_out;

   assign id_hs         = id_valid_q && id_out_ready;
   assign retire        = hash_done && (outstanding_q != '0);
   assign blk_in_valid  = (state_q == STREAM) && data_in_valid;
   assign data_in_ready = (state_q == STREAM) && blk_in_ready;
   assign blk_load      = data_in_valid && data_in_ready;
   assign blk_in        = {data_in, cur_id_q, data_in_last};

   sha256_block_out_reg u_out_reg (
      .clk         (clk),
      .rst         (rst),
      .sync_rst    (sync_rst),
      .in_valid_i  (blk_in_valid),
      .in_ready_o  (blk_in_ready),
      .in_blk_i    (blk_in),
      .out_valid_o (data_out_valid),
      .out_ready_i (data_out_ready),
      .out_blk_o   (blk_out)
   );

   assign data_out      = blk_out.data;
   assign data_out_id   = blk_out.id;
   assign data_out_last = blk_out.last;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         id_next_q  <= '0;
         cur_id_q   <= '0;
         batch_q    <= '0;
         id_valid_q <= 1'b0;
         id_q       <= '0;
         id_last_q  <= 1'b0;
      end else if (sync_rst) begin
         state_q    <= IDLE;
         id_next_q  <= '0;
         cur_id_q   <= '0;
         batch_q    <= '0;
         id_valid_q <= 1'b0;
         id_q       <= '0;
         id_last_q  <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               // Credit exhaustion simply stalls here; the block stays upstream.
               if (en && data_in_valid && (outstanding_q < MAX_CNT)) begin
                  cur_id_q   <= id_next_q;
                  id_q       <= id_next_q;
                  id_valid_q <= 1'b1;
                  id_last_q  <= (batch_q == BATCH_LAST);
                  state_q    <= ID_PUSH;
               end
            end
            ID_PUSH: begin
               if (id_out_ready) begin
                  id_valid_q <= 1'b0;
                  id_last_q  <= 1'b0;
                  batch_q    <= (batch_q == BATCH_LAST) ? '0 : batch_q + SHA_BATCH_W'(1);
                  state_q    <= STREAM;
               end
            end
            STREAM: begin
               if (blk_load && data_in_last) begin
                  id_next_q <= sha_id_inc(cur_id_q);
                  state_q   <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // A retirement with nothing in flight is dropped and flagged.
   always_comb begin
      outstanding_d = outstanding_q;
      err_d         = err_q;
      if (hash_done && (outstanding_q == '0)) begin
         err_d = 1'b1;
      end
      if (id_hs && !retire) begin
         outstanding_d = outstanding_q + SHA_CNT_W'(1);
      end else if (!id_hs && retire) begin
         outstanding_d = outstanding_q - SHA_CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         outstanding_q <= '0;
         err_q         <= 1'b0;
      end else if (sync_rst) begin
         outstanding_q <= '0;
         err_q         <= 1'b0;
      end else begin
         outstanding_q <= outstanding_d;
         err_q         <= err_d;
      end
   end

   assign id_out             = id_q;
   assign id_out_last        = id_last_q;
   assign id_out_valid       = id_valid_q;
   assign status_outstanding = outstanding_q;
   assign status_err         = err_q;

endmodule

`default_nettype wire

// File: tb/tb_sha256_id_issuer.sv
// ============================================================================
// Module  : tb_sha256_id_issuer
// Purpose : Self-checking bench: transaction-level scoreboard for IDs, blocks
//           and credits plus directed scenarios with literal expectations.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sha256_id_issuer;

   localparam int MAX   = 2;
   localparam int BATCH = 4;

   logic         clk;
   logic         rst;
   logic         en;
   logic         sync_rst;
   logic [511:0] data_in;
   logic         data_in_last;
   logic         data_in_valid;
   logic         data_in_ready;
   logic [511:0] data_out;
   logic [5:0]   data_out_id;
   logic         data_out_last;
   logic         data_out_valid;
   logic         data_out_ready;
   logic [5:0]   id_out;
   logic         id_out_last;
   logic         id_out_valid;
   logic         id_out_ready;
   logic         hash_done;
   logic [6:0]   status_outstanding;
   logic         status_err;

   logic hash_auto;
   logic hash_man;
   logic auto_en;
   logic tog_en;
   assign hash_done = hash_auto | hash_man;

   sha256_id_issuer #(.MAX_OUTSTANDING(MAX), .BATCH_LEN(BATCH)) dut (
      .clk(clk), .rst(rst), .en(en), .sync_rst(sync_rst),
      .data_in(data_in), .data_in_last(data_in_last),
      .data_in_valid(data_in_valid), .data_in_ready(data_in_ready),
      .data_out(data_out), .data_out_id(data_out_id),
      .data_out_last(data_out_last), .data_out_valid(data_out_valid),
      .data_out_ready(data_out_ready),
      .id_out(id_out), .id_out_last(id_out_last),
      .id_out_valid(id_out_valid), .id_out_ready(id_out_ready),
      .hash_done(hash_done),
      .status_outstanding(status_outstanding), .status_err(status_err)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_w(input string name, input logic [511:0] act, input logic [511:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- scoreboard model ----------------
   typedef struct {
      logic [511:0] d;
      logic [5:0]   id;
      logic         last;
   } blk_t;

   blk_t         mq[$];
   int           m_out;
   bit           m_err;
   int           m_issued;
   int           m_pkt;
   bit           p_dstall;
   logic [511:0] s_d;
   logic [5:0]   s_did;
   logic         s_dlast;
   bit           p_istall;
   logic [5:0]   s_id;
   logic         s_ilast;

   int           log_id[$];
   bit           log_idl[$];
   int           log_oid[$];
   bit           log_ol[$];
   logic [31:0]  log_tag[$];

   always @(negedge clk) begin : compare
      bit   id_hs;
      bit   ret;
      blk_t e;
      if (rst || sync_rst) begin
         mq.delete();
         m_out    = 0;
         m_err    = 0;
         m_issued = 0;
         m_pkt    = 0;
         p_dstall = 0;
         p_istall = 0;
      end else begin
         chk("outstanding", 64'(status_outstanding), 64'(m_out));
         chk("status_err", 64'(status_err), 64'(m_err));
         if (p_dstall) begin
            chk("dout_hold_valid", 64'(data_out_valid), 64'd1);
            chk_w("dout_hold_data", data_out, s_d);
            chk("dout_hold_id", 64'(data_out_id), 64'(s_did));
            chk("dout_hold_last", 64'(data_out_last), 64'(s_dlast));
         end
         if (p_istall) begin
            chk("id_hold_valid", 64'(id_out_valid), 64'd1);
            chk("id_hold_value", 64'(id_out), 64'(s_id));
            chk("id_hold_last", 64'(id_out_last), 64'(s_ilast));
         end
         id_hs = id_out_valid && id_out_ready;
         if (id_hs) begin
            chk("id_value", 64'(id_out), 64'(m_issued % 64));
            chk("id_last", 64'(id_out_last), 64'((m_issued % BATCH) == BATCH - 1));
            chk("id_credit", 64'(m_out < MAX), 64'd1);
            log_id.push_back(int'(id_out));
            log_idl.push_back(id_out_last);
            m_issued++;
         end
         if (data_out_valid) begin
            chk("dout_has_entry", 64'(mq.size() > 0), 64'd1);
            if (mq.size() > 0) begin
               chk_w("dout_data", data_out, mq[0].d);
               chk("dout_id", 64'(data_out_id), 64'(mq[0].id));
               chk("dout_last", 64'(data_out_last), 64'(mq[0].last));
               if (data_out_ready) begin
                  log_oid.push_back(int'(data_out_id));
                  log_ol.push_back(data_out_last);
                  log_tag.push_back(data_out[31:0]);
                  void'(mq.pop_front());
               end
            end
         end
         if (data_in_valid && data_in_ready) begin
            // The packet's ID must already be out, and only that packet's ID.
            chk("id_before_data", 64'(m_issued), 64'(m_pkt + 1));
            e.d    = data_in;
            e.id   = 6'(m_pkt % 64);
            e.last = data_in_last;
            mq.push_back(e);
            if (data_in_last) m_pkt++;
         end
         ret = hash_done && (m_out > 0);
         if (hash_done && m_out == 0) m_err = 1;
         m_out = m_out + (id_hs ? 1 : 0) - (ret ? 1 : 0);
         p_dstall = data_out_valid && !data_out_ready;
         s_d      = data_out;
         s_did    = data_out_id;
         s_dlast  = data_out_last;
         p_istall = id_out_valid && !id_out_ready;
         s_id     = id_out;
         s_ilast  = id_out_last;
      end
   end

   // Retire each packet one cycle after its last block leaves, when enabled.
   initial begin : auto_hash
      bit fire;
      hash_auto = 1'b0;
      forever begin
         @(negedge clk);
         fire = auto_en && !rst && !sync_rst && data_out_valid && data_out_ready && data_out_last;
         @(posedge clk);
         #1 hash_auto = fire;
      end
   end

   initial begin : ready_toggle
      data_out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1 data_out_ready = tog_en ? !data_out_ready : 1'b1;
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   // ---------------- stimulus helpers ----------------
   task automatic put_block(input logic [31:0] tag, input logic last);
      bit done;
      data_in       = {16{tag}};
      data_in_last  = last;
      data_in_valid = 1'b1;
      done = 0;
      for (int t = 0; t < 300 && !done; t++) begin
         @(negedge clk);
         if (data_in_ready) done = 1;
         @(posedge clk);
         #1;
      end
      data_in_valid = 1'b0;
      chk("in_handshake", 64'(done), 64'd1);
   endtask

   task automatic send_pkt(input int pkt, input int n);
      for (int b = 0; b < n; b++) put_block(32'(pkt * 256 + b), b == n - 1);
   endtask

   task automatic wait_drain();
      bit done;
      done = 0;
      for (int t = 0; t < 200 && !done; t++) begin
         @(negedge clk);
         if (!data_out_valid && !id_out_valid) done = 1;
      end
      chk("drain", 64'(done), 64'd1);
   endtask

   task automatic clear_logs();
      log_id.delete();
      log_idl.delete();
      log_oid.delete();
      log_ol.delete();
      log_tag.delete();
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst           = 1'b1;
      data_in_valid = 1'b0;
      hash_man      = 1'b0;
      id_out_ready  = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      clear_logs();
   endtask

   // ---------------- directed scenarios ----------------
   initial begin : stim
      int exp_oid[6];
      bit exp_ol[6];
      bit done;
      exp_oid = '{0, 0, 1, 1, 2, 2};
      exp_ol  = '{0, 1, 0, 1, 0, 1};

      rst = 1'b1; sync_rst = 1'b0; en = 1'b1;
      data_in = '0; data_in_last = 1'b0; data_in_valid = 1'b0;
      id_out_ready = 1'b1; hash_man = 1'b0; auto_en = 1'b0; tog_en = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      @(negedge clk);
      chk("rst_data_out", data_out[63:0], 64'd0);
      chk("rst_dout_valid", 64'(data_out_valid), 64'd0);
      chk("rst_id_valid", 64'(id_out_valid), 64'd0);
      chk("rst_id_out", 64'(id_out), 64'd0);
      chk("rst_in_ready", 64'(data_in_ready), 64'd0);
      chk("rst_outstanding", 64'(status_outstanding), 64'd0);

      // 1: three 2-block packets; en low first must hold everything off
      auto_en = 1'b1;
      en = 1'b0;
      data_in = '0; data_in_last = 1'b0; data_in_valid = 1'b1;
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("en_low_no_id", 64'(id_out_valid), 64'd0);
      chk("en_low_no_ready", 64'(data_in_ready), 64'd0);
      en = 1'b1;
      for (int p = 0; p < 3; p++) send_pkt(p, 2);
      wait_drain();
      chk("t1_id_count", 64'(log_id.size()), 64'd3);
      for (int i = 0; i < 3 && i < log_id.size(); i++) chk("t1_id", 64'(log_id[i]), 64'(i));
      chk("t1_blk_count", 64'(log_oid.size()), 64'd6);
      for (int i = 0; i < 6 && i < log_oid.size(); i++) begin
         chk("t1_dout_id", 64'(log_oid[i]), 64'(exp_oid[i]));
         chk("t1_dout_last", 64'(log_ol[i]), 64'(exp_ol[i]));
      end

      // 2: credit exhaustion at MAX=2 without retirement
      do_reset();
      auto_en = 1'b0;
      send_pkt(0, 1);
      send_pkt(1, 1);
      data_in = {16{32'h0000_0200}}; data_in_last = 1'b1; data_in_valid = 1'b1;
      repeat (6) @(posedge clk);
      @(negedge clk);
      chk("t2_stall_ready", 64'(data_in_ready), 64'd0);
      chk("t2_stall_id", 64'(id_out_valid), 64'd0);
      chk("t2_stall_cnt", 64'(status_outstanding), 64'd2);
      @(posedge clk); #1 hash_man = 1'b1;
      @(posedge clk); #1 hash_man = 1'b0;
      put_block(32'h0000_0200, 1'b1);
      wait_drain();
      chk("t2_id_count", 64'(log_id.size()), 64'd3);
      if (log_id.size() == 3) chk("t2_third_id", 64'(log_id[2]), 64'd2);
      chk("t2_final_cnt", 64'(status_outstanding), 64'd2);

      // 3: batch markers on IDs 3 and 7 over 9 packets
      do_reset();
      auto_en = 1'b1;
      for (int p = 0; p < 9; p++) send_pkt(p, 1);
      wait_drain();
      chk("t3_id_count", 64'(log_id.size()), 64'd9);
      for (int i = 0; i < log_id.size(); i++) begin
         chk("t3_id", 64'(log_id[i]), 64'(i));
         chk("t3_batch_last", 64'(log_idl[i]), 64'(i == 3 || i == 7));
      end

      // 4: 5-block packet against a toggling consumer
      do_reset();
      tog_en = 1'b1;
      send_pkt(0, 5);
      wait_drain();
      tog_en = 1'b0;
      chk("t4_blk_count", 64'(log_tag.size()), 64'd5);
      for (int i = 0; i < log_tag.size(); i++) chk("t4_tag", 64'(log_tag[i]), 64'(i));

      // 5: spurious retirement, then retirement coincident with an ID push
      do_reset();
      auto_en = 1'b0;
      @(posedge clk); #1 hash_man = 1'b1;
      @(posedge clk); #1 hash_man = 1'b0;
      @(negedge clk);
      chk("t5_err_set", 64'(status_err), 64'd1);
      chk("t5_cnt_zero", 64'(status_outstanding), 64'd0);
      do_reset();
      send_pkt(0, 1);
      wait_drain();
      chk("t5_cnt_one", 64'(status_outstanding), 64'd1);
      id_out_ready = 1'b0;
      data_in = {16{32'h0000_0100}}; data_in_last = 1'b1; data_in_valid = 1'b1;
      done = 0;
      for (int t = 0; t < 50 && !done; t++) begin
         @(negedge clk);
         if (id_out_valid) done = 1;
      end
      chk("t5_id_pending", 64'(done), 64'd1);
      @(posedge clk); #1 id_out_ready = 1'b1; hash_man = 1'b1;
      @(posedge clk); #1 hash_man = 1'b0;
      @(negedge clk);
      chk("t5_cnt_coincident", 64'(status_outstanding), 64'd1);
      chk("t5_no_err", 64'(status_err), 64'd0);
      put_block(32'h0000_0100, 1'b1);
      wait_drain();

      // 6: ID wrap over 70 packets, then async reset mid-packet
      do_reset();
      auto_en = 1'b1;
      for (int p = 0; p < 70; p++) send_pkt(p, 1);
      wait_drain();
      chk("t6_id_count", 64'(log_id.size()), 64'd70);
      if (log_id.size() == 70) begin
         chk("t6_id63", 64'(log_id[63]), 64'd63);
         chk("t6_id64_wrap", 64'(log_id[64]), 64'd0);
         chk("t6_id69", 64'(log_id[69]), 64'd5);
      end
      put_block(32'h0000_7700, 1'b0);
      #1 rst = 1'b1;
      #1;
      chk("t6_rst_dout_valid", 64'(data_out_valid), 64'd0);
      chk("t6_rst_id_valid", 64'(id_out_valid), 64'd0);
      chk("t6_rst_in_ready", 64'(data_in_ready), 64'd0);
      @(posedge clk); #1 rst = 1'b0;
      clear_logs();
      send_pkt(0, 1);
      wait_drain();
      chk("t6_post_rst_count", 64'(log_id.size()), 64'd1);
      if (log_id.size() == 1) chk("t6_post_rst_id", 64'(log_id[0]), 64'd0);

      // synchronous reset mid-packet
      send_pkt(1, 1);
      wait_drain();
      put_block(32'h0000_0200, 1'b0);
      sync_rst = 1'b1;
      @(posedge clk); #1 sync_rst = 1'b0;
      @(negedge clk);
      chk("srst_dout_valid", 64'(data_out_valid), 64'd0);
      chk("srst_id_valid", 64'(id_out_valid), 64'd0);
      chk("srst_cnt", 64'(status_outstanding), 64'd0);
      clear_logs();
      send_pkt(0, 1);
      wait_drain();
      chk("srst_next_count", 64'(log_id.size()), 64'd1);
      if (log_id.size() == 1) chk("srst_next_id", 64'(log_id[0]), 64'd0);

      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
